// File: rtl/vga_music_seq.sv
// vga_music_seq
// Frame-synchronous multi-channel square-wave sequencer for the VGA demos.
// The beam position is the timebase. A line tick occurs at x==0, and a frame
// tick occurs at x==0 && y==0. Each channel plays its own writable step
// pattern of note divisors, and each note has a decaying envelope. The
// channels are summed into `level`, which is rendered as a 1-bit pulse
// on every scan line.
//
// Ports
//   clk, rst         pixel clock, asynchronous active-high reset
//   x, y             current beam column / row
//   start, stop      1-cycle pulses: play from step 0 / halt and silence
//   loop             1 = wrap after the last step, 0 = finish in DONE
//   speed            frames per step (0 behaves as 1)
//   decay            envelope decrement per frame
//   wr_en/wr_ch/wr_addr/wr_data   pattern RAM write port
//   sound            registered PWM audio bit
//   level            registered mixed amplitude
//   step             current step index
//   busy, done       registered state flags (PLAY / DONE)
module vga_music_seq #(
  parameter int NUM_CH    = 2,
  parameter int STEPS     = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int DIV_W     = 8,
  parameter int ENV_W     = 5,
  parameter int PWM_X0    = 256,
  parameter int PWM_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [X_W-1:0]           x,
  input  logic [Y_W-1:0]           y,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [3:0]               speed,
  input  logic [ENV_W-1:0]         decay,
  input  logic                     wr_en,
  input  logic [1:0]               wr_ch,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [DIV_W-1:0]         wr_data,
  output logic                     sound,
  output logic [ENV_W+1:0]         level,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     busy,
  output logic                     done
);

  localparam int SA_W  = $clog2(STEPS);
  localparam int LVL_W = ENV_W + 2;
  localparam int CMP_W = X_W + ENV_W + 2;
  localparam logic [ENV_W-1:0] ENV_MAX   = '1;
  localparam logic [SA_W-1:0]  LAST_STEP = SA_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t             state_q, state_d;
  logic [SA_W-1:0]    step_q, step_d;
  logic [3:0]         frame_in_step_q, frame_in_step_d;
  logic [DIV_W-1:0]   cnt_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_d [NUM_CH];
  logic [DIV_W-1:0]   div_cur_q [NUM_CH];
  logic [DIV_W-1:0]   div_cur_d [NUM_CH];
  logic [ENV_W-1:0]   env_q [NUM_CH];
  logic [ENV_W-1:0]   env_d [NUM_CH];
  logic [NUM_CH-1:0]  phase_q, phase_d;
  logic [DIV_W-1:0]   ram_q [NUM_CH][STEPS];
  logic [DIV_W-1:0]   ram_d [NUM_CH][STEPS];
  logic [LVL_W-1:0]   level_q, level_d;
  logic               sound_q, sound_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               line_tick, frame_tick, load;
  logic [3:0]         speed_m1;
  logic [CMP_W-1:0]   x_ext, pwm_lo, pwm_hi;

  // Sequencer control: state, step index and frame-within-step counter.
  // stop beats start, and start always restarts at step 0 with a note load.
  always_comb begin
    line_tick       = (x == '0);
    frame_tick      = line_tick && (y == '0);
    speed_m1        = (speed == 4'd0) ? 4'd0 : speed - 4'd1;
    state_d         = state_q;
    step_d          = step_q;
    frame_in_step_d = frame_in_step_q;
    load            = 1'b0;
    if (stop) begin
      state_d         = IDLE;
      step_d          = '0;
      frame_in_step_d = '0;
    end else if (start) begin
      state_d         = PLAY;
      step_d          = '0;
      frame_in_step_d = '0;
      load            = 1'b1;
    end else if (state_q == PLAY && frame_tick) begin
      // >= rather than == so that lowering speed below the frames already
      // played ends the step now instead of waiting for the counter to wrap
      if (frame_in_step_q >= speed_m1) begin
        frame_in_step_d = '0;
        if (step_q == LAST_STEP) begin
          if (loop) begin
            step_d = '0;
            load   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          step_d = step_q + SA_W'(1);
          load   = 1'b1;
        end
      end else begin
        frame_in_step_d = frame_in_step_q + 4'd1;
      end
    end
  end

  // Per-channel voice: note latch, envelope and square-wave oscillator.
  // A step load wins over both the envelope decay and the oscillator update.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      div_cur_d[c] = div_cur_q[c];
      env_d[c]     = env_q[c];
      cnt_d[c]     = cnt_q[c];
      phase_d[c]   = phase_q[c];
      if (load) begin
        div_cur_d[c] = ram_q[c][step_d];
        env_d[c]     = ENV_MAX;
        cnt_d[c]     = '0;
        phase_d[c]   = 1'b0;
      end else begin
        if (frame_tick)
          env_d[c] = (env_q[c] > decay) ? env_q[c] - decay : '0;
        if (state_q == PLAY && line_tick) begin
          if (div_cur_q[c] == '0) begin
            cnt_d[c]   = '0;
            phase_d[c] = 1'b0;
          end else if (cnt_q[c] >= div_cur_q[c]) begin
            cnt_d[c]   = '0;
            phase_d[c] = ~phase_q[c];
          end else begin
            cnt_d[c] = cnt_q[c] + DIV_W'(1);
          end
        end
      end
    end
  end

  // Pattern RAM write port. Channel selects beyond NUM_CH match no row.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < STEPS; s++)
        ram_d[c][s] = (wr_en && int'(wr_ch) == c && int'(wr_addr) == s)
                      ? wr_data : ram_q[c][s];
  end

  // Mixer and line PWM. The pulse compare is widened so that
  // PWM_X0 + (level << PWM_SHIFT) cannot wrap.
  always_comb begin
    level_d = '0;
    if (state_q == PLAY)
      for (int c = 0; c < NUM_CH; c++)
        if (phase_q[c])
          level_d = level_d + LVL_W'(env_q[c]);
    x_ext   = CMP_W'(x);
    pwm_lo  = CMP_W'(PWM_X0);
    pwm_hi  = pwm_lo + (CMP_W'(level_q) << PWM_SHIFT);
    sound_d = (x_ext >= pwm_lo) && (x_ext < pwm_hi);
    busy_d  = (state_d == PLAY);
    done_d  = (state_d == DONE);
  end

  // State register. Reset clears everything, including the pattern RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      step_q          <= '0;
      frame_in_step_q <= '0;
      phase_q         <= '0;
      level_q         <= '0;
      sound_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]     <= '0;
        div_cur_q[c] <= '0;
        env_q[c]     <= '0;
        for (int s = 0; s < STEPS; s++)
          ram_q[c][s] <= '0;
      end
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      frame_in_step_q <= frame_in_step_d;
      phase_q         <= phase_d;
      level_q         <= level_d;
      sound_q         <= sound_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]     <= cnt_d[c];
        div_cur_q[c] <= div_cur_d[c];
        env_q[c]     <= env_d[c];
        for (int s = 0; s < STEPS; s++)
          ram_q[c][s] <= ram_d[c][s];
      end
    end
  end

  assign sound = sound_q;
  assign level = level_q;
  assign step  = step_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
